// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: counter width and the
// power-on 640x480@60 segment lengths and sync polarities.
package vga_timing_pkg;

    localparam int VGA_CNT_W = 12;

    localparam int VGA_H_ACT = 640;
    localparam int VGA_H_FP  = 16;
    localparam int VGA_H_SYN = 96;
    localparam int VGA_H_BP  = 48;

    localparam int VGA_V_ACT = 480;
    localparam int VGA_V_FP  = 10;
    localparam int VGA_V_SYN = 2;
    localparam int VGA_V_BP  = 33;

    localparam logic VGA_H_POL = 1'b0;
    localparam logic VGA_V_POL = 1'b0;

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter, wrap detect and
// combinational sync/active decode for the current position.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int CNT_W = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic [CNT_W-1:0] act,
    input  logic [CNT_W-1:0] fp,
    input  logic [CNT_W-1:0] syn,
    input  logic [CNT_W-1:0] bp,
    input  logic             pol,
    output logic [CNT_W+1:0] cnt,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TW = CNT_W + 2;

    logic [TW-1:0] syn_lo;
    logic [TW-1:0] syn_hi;
    logic [TW-1:0] total;

    // Extra two bits keep the four-segment sum from overflowing.
    assign syn_lo = TW'(act) + TW'(fp);
    assign syn_hi = syn_lo + TW'(syn);
    assign total  = syn_hi + TW'(bp);

    assign wrap   = (cnt == total - TW'(1));
    assign active = (cnt < TW'(act));
    assign sync   = (cnt >= syn_lo && cnt < syn_hi) ? pol : ~pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= wrap ? '0 : cnt + TW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync generator with run-time timing reconfiguration that is
// deferred to the frame boundary so a frame never changes shape.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W   = VGA_CNT_W,
    parameter int   H_ACT_D = VGA_H_ACT,
    parameter int   H_FP_D  = VGA_H_FP,
    parameter int   H_SYN_D = VGA_H_SYN,
    parameter int   H_BP_D  = VGA_H_BP,
    parameter int   V_ACT_D = VGA_V_ACT,
    parameter int   V_FP_D  = VGA_V_FP,
    parameter int   V_SYN_D = VGA_V_SYN,
    parameter int   V_BP_D  = VGA_V_BP,
    parameter logic H_POL_D = VGA_H_POL,
    parameter logic V_POL_D = VGA_V_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_syn,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_syn,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_h_pol,
    input  logic             cfg_v_pol,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             cfg_busy,
    output logic             cfg_err
);

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_syn;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_syn;
        logic [CNT_W-1:0] v_bp;
        logic             h_pol;
        logic             v_pol;
    } timing_t;

    localparam timing_t TIM_D = '{
        h_act: CNT_W'(H_ACT_D),
        h_fp:  CNT_W'(H_FP_D),
        h_syn: CNT_W'(H_SYN_D),
        h_bp:  CNT_W'(H_BP_D),
        v_act: CNT_W'(V_ACT_D),
        v_fp:  CNT_W'(V_FP_D),
        v_syn: CNT_W'(V_SYN_D),
        v_bp:  CNT_W'(V_BP_D),
        h_pol: H_POL_D,
        v_pol: V_POL_D
    };

    timing_t cur;
    timing_t pend;
    timing_t cfg_in;

    logic [CNT_W+1:0] h_cnt;
    logic [CNT_W+1:0] v_cnt;
    logic h_wrap, v_wrap;
    logic h_sync, v_sync;
    logic h_act_n, v_act_n;
    logic de_n;
    logic cfg_ok;
    logic load_ok;
    logic frame_wrap;

    assign cfg_in = '{
        h_act: cfg_h_act, h_fp: cfg_h_fp,
        h_syn: cfg_h_syn, h_bp: cfg_h_bp,
        v_act: cfg_v_act, v_fp: cfg_v_fp,
        v_syn: cfg_v_syn, v_bp: cfg_v_bp,
        h_pol: cfg_h_pol, v_pol: cfg_v_pol
    };

    // Zero-length porches are fine; zero active or sync is not.
    assign cfg_ok = (cfg_h_act != '0) && (cfg_h_syn != '0) &&
                    (cfg_v_act != '0) && (cfg_v_syn != '0);
    assign load_ok    = cfg_load & cfg_ok;
    assign frame_wrap = en & h_wrap & v_wrap;
    assign de_n       = h_act_n & v_act_n;

    vga_axis_timer #(.CNT_W(CNT_W)) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (en),
        .act     (cur.h_act),
        .fp      (cur.h_fp),
        .syn     (cur.h_syn),
        .bp      (cur.h_bp),
        .pol     (cur.h_pol),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .sync    (h_sync),
        .active  (h_act_n)
    );

    vga_axis_timer #(.CNT_W(CNT_W)) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (en & h_wrap),
        .act     (cur.v_act),
        .fp      (cur.v_fp),
        .syn     (cur.v_syn),
        .bp      (cur.v_bp),
        .pol     (cur.v_pol),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .sync    (v_sync),
        .active  (v_act_n)
    );

    // A load landing on the wrap edge takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= TIM_D;
            pend     <= '0;
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_load & ~cfg_ok;
            if (frame_wrap) begin
                if (load_ok) begin
                    cur <= cfg_in;
                end else if (cfg_busy) begin
                    cur <= pend;
                end
                cfg_busy <= 1'b0;
            end else if (load_ok) begin
                pend     <= cfg_in;
                cfg_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~H_POL_D;
            vsync       <= ~V_POL_D;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= h_sync;
            vsync       <= v_sync;
            de          <= de_n;
            x           <= de_n ? h_cnt[CNT_W-1:0] : '0;
            y           <= de_n ? v_cnt[CNT_W-1:0] : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench: a frame-position reference model
// queues expected outputs, a monitor pops and compares each cycle.
module tb_vga_timing_gen;

    localparam int HA = 10, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam bit HP = 1'b1, VP = 1'b0;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        bit hsync, vsync, de, ls, fs, busy, err;
        int x, y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [11:0] cfg_h_act = '0, cfg_h_fp = '0;
    logic [11:0] cfg_h_syn = '0, cfg_h_bp = '0;
    logic [11:0] cfg_v_act = '0, cfg_v_fp = '0;
    logic [11:0] cfg_v_syn = '0, cfg_v_bp = '0;
    logic        cfg_h_pol = 1'b0, cfg_v_pol = 1'b0;
    logic        hsync, vsync, de, line_start, frame_start;
    logic [11:0] x, y;
    logic        cfg_busy, cfg_err;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t q[$];

    tim_t def_t = '{HA, HF, HS, HB, VA, VF, VS, VB, HP, VP};
    tim_t m_cur, m_pend;
    bit   m_busy;
    int   m_pos;
    exp_t m_out;

    vga_timing_gen #(
        .CNT_W(12),
        .H_ACT_D(HA), .H_FP_D(HF), .H_SYN_D(HS), .H_BP_D(HB),
        .V_ACT_D(VA), .V_FP_D(VF), .V_SYN_D(VS), .V_BP_D(VB),
        .H_POL_D(HP), .V_POL_D(VP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp),
        .cfg_h_syn(cfg_h_syn), .cfg_h_bp(cfg_h_bp),
        .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp),
        .cfg_v_syn(cfg_v_syn), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start),
        .x(x), .y(y), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic int htot(tim_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int vtot(tim_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    function automatic bit in_sync(int p, int a, int f, int s);
        return (p >= a + f) && (p < a + f + s);
    endfunction

    function automatic tim_t rand_cfg(bit allow_zero);
        tim_t t;
        int lo = allow_zero ? 0 : 1;
        t.ha = $urandom_range(6, lo);
        t.hf = $urandom_range(2, 0);
        t.hs = $urandom_range(3, lo);
        t.hb = $urandom_range(2, 0);
        t.va = $urandom_range(4, lo);
        t.vf = $urandom_range(2, 0);
        t.vs = $urandom_range(2, lo);
        t.vb = $urandom_range(2, 0);
        t.hp = 1'($urandom_range(1, 0));
        t.vp = 1'($urandom_range(1, 0));
        return t;
    endfunction

    function automatic exp_t reset_out();
        exp_t o;
        o.hsync = ~def_t.hp;
        o.vsync = ~def_t.vp;
        o.de = 0; o.ls = 0; o.fs = 0;
        o.busy = 0; o.err = 0;
        o.x = 0; o.y = 0;
        return o;
    endfunction

    // Model works from the pixel's linear position in the frame.
    task automatic model_step(bit e, bit ld, tim_t c);
        int  ht, vt, h, v;
        bit  ok, wrap;
        if (!rst_n) begin
            m_cur  = def_t;
            m_busy = 0;
            m_pos  = 0;
            m_out  = reset_out();
            return;
        end
        ht = htot(m_cur);
        vt = vtot(m_cur);
        h  = m_pos % ht;
        v  = m_pos / ht;
        ok = c.ha != 0 && c.hs != 0 && c.va != 0 && c.vs != 0;
        wrap = e && (m_pos == ht * vt - 1);
        if (e) begin
            m_out.hsync = in_sync(h, m_cur.ha, m_cur.hf, m_cur.hs)
                          ? m_cur.hp : ~m_cur.hp;
            m_out.vsync = in_sync(v, m_cur.va, m_cur.vf, m_cur.vs)
                          ? m_cur.vp : ~m_cur.vp;
            m_out.de = (h < m_cur.ha) && (v < m_cur.va);
            m_out.x  = m_out.de ? h : 0;
            m_out.y  = m_out.de ? v : 0;
            m_out.ls = (h == 0);
            m_out.fs = (m_pos == 0);
        end
        m_out.err = ld && !ok;
        if (wrap) begin
            if (ld && ok) m_cur = c;
            else if (m_busy) m_cur = m_pend;
            m_busy = 0;
        end else if (ld && ok) begin
            m_pend = c;
            m_busy = 1;
        end
        m_out.busy = m_busy;
        if (e) m_pos = wrap ? 0 : m_pos + 1;
    endtask

    task automatic tick(bit e, bit ld, tim_t c, bit rn = 1'b1);
        @(negedge clk);
        rst_n     = rn;
        en        = e;
        cfg_load  = ld;
        cfg_h_act = 12'(c.ha); cfg_h_fp = 12'(c.hf);
        cfg_h_syn = 12'(c.hs); cfg_h_bp = 12'(c.hb);
        cfg_v_act = 12'(c.va); cfg_v_fp = 12'(c.vf);
        cfg_v_syn = 12'(c.vs); cfg_v_bp = 12'(c.vb);
        cfg_h_pol = c.hp;      cfg_v_pol = c.vp;
        model_step(e, ld, c);
        q.push_back(m_out);
    endtask

    task automatic run(int n, int en_pct);
        tim_t z = def_t;
        for (int i = 0; i < n; i++)
            tick($urandom_range(99, 0) < en_pct, 1'b0, z);
    endtask

    task automatic goto_wrap_minus1();
        tim_t z = def_t;
        for (int g = 0; g < 5000; g++) begin
            if (m_pos == htot(m_cur) * vtot(m_cur) - 1) return;
            tick(1'b1, 1'b0, z);
        end
        n_fail++;
        $display("FAIL wrap_seek: pos=%0d never reached wrap", m_pos);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                ex = q.pop_front();
                n_vec++;
                if (hsync !== ex.hsync || vsync !== ex.vsync ||
                    de !== ex.de || line_start !== ex.ls ||
                    frame_start !== ex.fs || cfg_busy !== ex.busy ||
                    cfg_err !== ex.err || x !== 12'(ex.x) ||
                    y !== 12'(ex.y)) begin
                    n_fail++;
                    $display("FAIL vec%0d t=%0t got hs%b vs%b de%b x%0d y%0d ls%b fs%b bsy%b err%b want hs%b vs%b de%b x%0d y%0d ls%b fs%b bsy%b err%b",
                        n_vec, $time, hsync, vsync, de, x, y,
                        line_start, frame_start, cfg_busy, cfg_err,
                        ex.hsync, ex.vsync, ex.de, ex.x, ex.y,
                        ex.ls, ex.fs, ex.busy, ex.err);
                end
            end
        end
    end

    initial begin : driver
        tim_t c, c2;
        m_cur = def_t; m_pend = def_t; m_busy = 0; m_pos = 0;
        m_out = reset_out();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, def_t, 1'b0);
        run(2 * 170 + 20, 100);
        // en-low freeze mid-line
        run(4, 100);
        run(3, 0);
        run(60, 85);
        // invalid load: zero sync width
        c = rand_cfg(1'b0);
        c.hs = 0;
        tick(1'b1, 1'b1, c);
        run(200, 100);
        // small 8x6 frame: h 4/1/2/1, v 3/1/1/1
        c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
        tick(1'b1, 1'b1, c);
        run(170 + 2 * 48 + 10, 100);
        // two loads mid-frame, last one wins
        run(5, 100);
        if (m_pos == htot(m_cur) * vtot(m_cur) - 1) run(1, 100);
        c2 = rand_cfg(1'b0);
        tick(1'b1, 1'b1, c2);
        run(3, 100);
        c2.ha = 6;
        tick(1'b1, 1'b1, c2);
        run(48 + 2 * htot(c2) * vtot(c2), 100);
        // load exactly on the wrap edge
        for (int k = 0; k < 3; k++) begin
            goto_wrap_minus1();
            tick(1'b1, 1'b1, rand_cfg(1'b0));
            run(30, 90);
        end
        // random traffic with occasional (possibly bad) loads
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39, 0) == 0)
                tick($urandom_range(9, 0) != 0, 1'b1,
                     rand_cfg($urandom_range(2, 0) == 0));
            else
                run(1, 90);
        end
        // reset mid-frame while a config is pending
        run(7, 100);
        if (m_pos == htot(m_cur) * vtot(m_cur) - 1) run(1, 100);
        tick(1'b1, 1'b1, rand_cfg(1'b0));
        run(2, 100);
        tick(1'b1, 1'b0, def_t, 1'b0);
        tick(1'b1, 1'b0, def_t, 1'b0);
        run(2 * 170 + 15, 100);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
